serial_sub_ctrl: RTL and testbench

Bit-serial subtract controller that sequences one `full_subtractor` bit cell over a WIDTH-bit operand pair. It uses one bit cell per cycle and keeps the borrow in a flop, which trades latency for area. It latches operands on a start handshake and shifts them LSB-first through the cell. It then presents the difference with borrow, signed-overflow and zero flags. The block is the sequencing front end for the subtractor path of the ALU.

---
 rtl/serial_sub_ctrl_if.sv | 26 ++
 rtl/serial_sub_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result bundle of the bit-serial subtract controller.
// Requester drives start and operands; the controller returns busy, done pulse and flags.
`timescale 1ns/1ps
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_overflow;
    logic             out_zero;

    modport master (
        output in_start, in_a, in_b,
        input  out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero
    );

    modport slave (
        input  in_start, in_a, in_b,
        output out_busy, out_done, out_diff, out_borrow, out_overflow, out_zero
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b through one full-subtractor cell, LSB first; done pulses WIDTH+1 cycles after accept.
// No backpressure: start is taken only while idle, otherwise ignored; results hold until the next completion.
`timescale 1ns/1ps
module full_subtractor (
    input  logic in_a,
    input  logic in_b,
    input  logic in_borrow,
    output logic out_sub,
    output logic out_borrow
);
    assign out_sub    = in_a ^ in_b ^ in_borrow;
    assign out_borrow = (~in_a & in_b) | (~(in_a ^ in_b) & in_borrow);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    serial_sub_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow_ff;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_sub;
    logic             w_cell_borrow;
    logic [WIDTH-1:0] w_diff_final;

    assign w_accept     = (r_state == S_IDLE) && bus.in_start;
    assign w_run        = (r_state == S_RUN);
    assign w_last       = w_run && (r_cnt == LAST_BIT);
    // The bit produced on the final edge is not yet in d_sr, so splice it in here.
    assign w_diff_final = {w_sub, r_d_sr[WIDTH-1:1]};

    full_subtractor u_cell (
        .in_a       (r_a_sr[0]),
        .in_b       (r_b_sr[0]),
        .in_borrow  (r_borrow_ff),
        .out_sub    (w_sub),
        .out_borrow (w_cell_borrow)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == LAST_BIT) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out_busy = 1'b0;
        bus.out_done = 1'b0;
        case (r_state)
            S_RUN:  bus.out_busy = 1'b1;
            S_DONE: begin
                bus.out_busy = 1'b1;
                bus.out_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_d_sr      <= '0;
            r_cnt       <= '0;
            r_borrow_ff <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
        end else if (w_accept) begin
            r_a_sr      <= bus.in_a;
            r_b_sr      <= bus.in_b;
            r_a_msb     <= bus.in_a[WIDTH-1];
            r_b_msb     <= bus.in_b[WIDTH-1];
            r_cnt       <= '0;
            r_borrow_ff <= 1'b0;
        end else if (w_run) begin
            r_d_sr      <= w_diff_final;
            r_a_sr      <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr      <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_borrow_ff <= w_cell_borrow;
            r_cnt       <= r_cnt + CW'(1);
        end
    end

    // Overflow: operand signs differ and the result sign departs from the minuend's.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_last) begin
            r_diff     <= w_diff_final;
            r_borrow   <= w_cell_borrow;
            r_overflow <= (r_a_msb != r_b_msb) && (w_sub != r_a_msb);
            r_zero     <= (w_diff_final == '0);
        end
    end

    assign bus.out_diff     = r_diff;
    assign bus.out_borrow   = r_borrow;
    assign bus.out_overflow = r_overflow;
    assign bus.out_zero     = r_zero;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: arithmetic/timing model compared every cycle plus literal checks.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: operation is a-b on latched operands, results appear WIDTH edges after accept.
    logic         m_busy   = 1'b0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
    logic         m_ov     = 1'b0;
    logic         m_zero   = 1'b0;
    logic [W-1:0] m_a      = '0;
    logic [W-1:0] m_b      = '0;
    int           edge_n   = 0;
    int           acc_edge = 0;
    int           sa, sb, sd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0;
            m_borrow = 1'b0; m_ov = 1'b0; m_zero = 1'b0;
        end else begin
            edge_n++;
            if (!m_busy) begin
                if (bus.in_start) begin
                    m_a = bus.in_a;
                    m_b = bus.in_b;
                    acc_edge = edge_n;
                    m_busy = 1'b1;
                end
            end else if (edge_n == acc_edge + W) begin
                m_diff   = m_a - m_b;
                m_borrow = (m_a < m_b);
                sa = int'($signed(m_a));
                sb = int'($signed(m_b));
                sd = sa - sb;
                m_ov   = (sd > 127) || (sd < -128);
                m_zero = (m_diff == '0);
                m_done = 1'b1;
            end else if (edge_n == acc_edge + W + 1) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy",   bus.out_busy,     m_busy);
            chk("cyc_done",   bus.out_done,     m_done);
            chk("cyc_diff",   bus.out_diff,     m_diff);
            chk("cyc_borrow", bus.out_borrow,   m_borrow);
            chk("cyc_ovf",    bus.out_overflow, m_ov);
            chk("cyc_zero",   bus.out_zero,     m_zero);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   bus.out_busy,     0);
        chk({tag, "_done"},   bus.out_done,     0);
        chk({tag, "_diff"},   bus.out_diff,     0);
        chk({tag, "_borrow"}, bus.out_borrow,   0);
        chk({tag, "_ovf"},    bus.out_overflow, 0);
        chk({tag, "_zero"},   bus.out_zero,     0);
    endtask

    // One operation; poke_k>0 re-pulses start with altered operands while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                          input logic eb, input logic eo, input logic ez,
                          input int poke_k, input string tag);
        int first_done = 0;
        int n_done = 0;
        int busy_cnt = 0;
        @(negedge clk);
        bus.in_start = 1'b1; bus.in_a = a; bus.in_b = b;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_start = 1'b0;
            if (poke_k > 0 && k == poke_k) begin
                bus.in_start = 1'b1; bus.in_a = ~a; bus.in_b = a;
            end
            if (poke_k > 0 && k == poke_k + 1) bus.in_start = 1'b0;
            if (bus.out_busy) busy_cnt++;
            if (bus.out_done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (!bus.out_busy) break;
        end
        chk({tag, "_done_at"},  first_done, 9);
        chk({tag, "_busy_len"}, busy_cnt, 9);
        chk({tag, "_n_done"},   n_done, 1);
        chk({tag, "_diff"},     bus.out_diff, exp_d);
        chk({tag, "_borrow"},   bus.out_borrow, eb);
        chk({tag, "_ovf"},      bus.out_overflow, eo);
        chk({tag, "_zero"},     bus.out_zero, ez);
    endtask

    initial begin
        int n_done;
        int prev;
        int low;
        bus.in_start = 1'b0; bus.in_a = '0; bus.in_b = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset0");
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 0, "a5_b3");
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 0, "a3_b5");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 0, "ovf_neg");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 0, "ovf_pos");
        run_op(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 3, "eq_poke");

        // Reset landing mid-run discards the operation.
        @(negedge clk);
        bus.in_start = 1'b1; bus.in_a = 8'hC3; bus.in_b = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        bus.in_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 0, "after_rst");

        // Start held high: restart every WIDTH+2 cycles.
        @(negedge clk);
        bus.in_start = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'h00;
        n_done = 0; prev = -1; low = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (bus.out_done) begin
                n_done++;
                chk("hold_diff", bus.out_diff, 8'hFF);
                if (prev >= 0) chk("hold_period", k - prev, 10);
                else chk("hold_first", k, 9);
                prev = k;
            end
            if (!bus.out_busy) low++;
            else if (low > 0) begin
                chk("hold_gap", low, 1);
                low = 0;
            end
        end
        bus.in_start = 1'b0;
        chk("hold_n_done", n_done, 3);
        low = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (!bus.out_busy) begin
                low = 1;
                break;
            end
        end
        chk("hold_idle", low, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
